// File: rtl/pipeline_controller.sv
// pipeline_controller
//   Run/step/halt sequencer and load-use/branch hazard controller for the
//   5-stage MIPS pipeline. It decides each cycle whether the pipeline
//   advances, stalls, squashes wrong-path work, or drains and freezes after
//   a HALT reaches EX/MEM. It also counts enabled cycles for the debug unit.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   run_req/step_req      enter continuous run / advance exactly one cycle
//   stop_req              leave continuous run
//   clear_req             leave HALTED and clear the cycle counter
//   halt_flag_e           HALT present in the EX/MEM register
//   branch_taken          taken branch/jump resolved this cycle
//   id_ex_mem_read/_rt    load in ID/EX and its destination register
//   if_id_rs/_rt          source registers of the instruction in ID
//   pipe_enable           global advance of all pipeline registers
//   pc_write/if_id_write  PC and IF/ID update enables
//   bubble_id_ex          zero the control buses into ID/EX
//   flush                 squash IF/ID, ID/EX and execute outputs
//   halted/busy           in HALTED / in RUN, STEP or DRAIN
//   cycle_count           enabled cycles since the last clear
module pipeline_controller #(
    parameter int unsigned NB           = 5,
    parameter int unsigned CW           = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          stop_req,
    input  logic          clear_req,
    input  logic          halt_flag_e,
    input  logic          branch_taken,
    input  logic          id_ex_mem_read,
    input  logic [NB-1:0] id_ex_rt,
    input  logic [NB-1:0] if_id_rs,
    input  logic [NB-1:0] if_id_rt,
    output logic          pipe_enable,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          bubble_id_ex,
    output logic          flush,
    output logic          halted,
    output logic          busy,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned  DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DRAIN,
        HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [CW-1:0] count_q, count_d;
    logic          pipe_enable_q;
    logic          halted_q;
    logic          busy_q;

    logic          hazard;
    logic          halt_squash;

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        count_d = count_q;

        if (pipe_enable_q) begin
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (run_req) begin
                    state_d = RUN;
                end else if (step_req) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt_flag_e) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (stop_req) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (halt_flag_e) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            HALTED: begin
                if (clear_req) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; status outputs are registered from the next state so
    // they stay glitch-free Moore outputs aligned with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            drain_q       <= '0;
            count_q       <= '0;
            pipe_enable_q <= 1'b0;
            halted_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            count_q       <= count_d;
            pipe_enable_q <= (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN);
            halted_q      <= (state_d == HALTED);
            busy_q        <= (state_d == RUN) || (state_d == STEP) || (state_d == DRAIN);
        end
    end

    // Load-use hazard: register 0 never carries a real dependency
    assign hazard = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // Everything younger than the HALT is squashed, from the cycle the HALT
    // is first seen until the drain completes.
    assign halt_squash = (state_q == DRAIN) ||
                         (halt_flag_e && ((state_q == RUN) || (state_q == STEP)));

    // Same-cycle hazard/branch controls, gated by the pipeline enable
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        bubble_id_ex = 1'b0;
        flush        = 1'b0;
        if (pipe_enable_q) begin
            if (halt_squash) begin
                flush = 1'b1;
            end else if (branch_taken) begin
                flush       = 1'b1;
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end else if (hazard) begin
                bubble_id_ex = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    assign pipe_enable = pipe_enable_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Testbench for pipeline_controller: a cycle model pushes the expected
// outputs for each cycle into a scoreboard queue; each test pops and
// compares after the DUT settles, plus direct checks of the headline
// behaviours with hand-derived constants.
module tb_pipeline_controller;

    localparam int NB = 5;
    localparam int CW = 32;
    localparam int DC = 2;

    logic          clk            = 1'b0;
    logic          reset          = 1'b0;
    logic          run_req        = 1'b0;
    logic          step_req       = 1'b0;
    logic          stop_req       = 1'b0;
    logic          clear_req      = 1'b0;
    logic          halt_flag_e    = 1'b0;
    logic          branch_taken   = 1'b0;
    logic          id_ex_mem_read = 1'b0;
    logic [NB-1:0] id_ex_rt       = '0;
    logic [NB-1:0] if_id_rs       = '0;
    logic [NB-1:0] if_id_rt       = '0;
    logic          pipe_enable;
    logic          pc_write;
    logic          if_id_write;
    logic          bubble_id_ex;
    logic          flush;
    logic          halted;
    logic          busy;
    logic [CW-1:0] cycle_count;

    pipeline_controller #(
        .NB(NB),
        .CW(CW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run_req(run_req),
        .step_req(step_req),
        .stop_req(stop_req),
        .clear_req(clear_req),
        .halt_flag_e(halt_flag_e),
        .branch_taken(branch_taken),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt),
        .pipe_enable(pipe_enable),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .bubble_id_ex(bubble_id_ex),
        .flush(flush),
        .halted(halted),
        .busy(busy),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // ctl = {pipe_enable, pc_write, if_id_write, bubble_id_ex, flush, halted, busy}
    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t sb_q[$];
    obs_t exp_o;
    obs_t act_o;
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    int            m_st   = 0;
    int            m_left = 0;
    logic [CW-1:0] m_cnt  = '0;

    function automatic logic [6:0] model_ctl();
        logic en, hz, pc, bub, fl;
        en  = (m_st >= 1) && (m_st <= 3);
        hz  = id_ex_mem_read && (id_ex_rt != 0) &&
              ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
        pc  = 1'b0;
        bub = 1'b0;
        fl  = 1'b0;
        if (en) begin
            if (m_st == 3 || halt_flag_e) begin
                fl = 1'b1;
            end else if (branch_taken) begin
                fl = 1'b1;
                pc = 1'b1;
            end else if (hz) begin
                bub = 1'b1;
            end else begin
                pc = 1'b1;
            end
        end
        return {en, pc, pc, bub, fl, (m_st == 4), en};
    endfunction

    task automatic model_reset();
        m_st   = 0;
        m_left = 0;
        m_cnt  = '0;
    endtask

    // Advance the model on the inputs of the current cycle, then cross the edge
    task automatic adv();
        if (m_st >= 1 && m_st <= 3) m_cnt = m_cnt + 1;
        case (m_st)
            0: if (run_req) m_st = 1; else if (step_req) m_st = 2;
            1: begin
                if (halt_flag_e) begin m_st = 3; m_left = DC - 1; end
                else if (stop_req) m_st = 0;
            end
            2: begin
                if (halt_flag_e) begin m_st = 3; m_left = DC - 1; end
                else m_st = 0;
            end
            3: if (m_left == 0) m_st = 4; else m_left = m_left - 1;
            4: if (clear_req) begin m_st = 0; m_cnt = '0; end
            default: m_st = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Queue this cycle's expectation, then sample the DUT mid-cycle
    task automatic tick();
        sb_q.push_back(obs_t'({model_ctl(), m_cnt}));
        @(negedge clk);
        act_o = obs_t'({pipe_enable, pc_write, if_id_write, bubble_id_ex,
                        flush, halted, busy, cycle_count});
    endtask

    task automatic clr();
        run_req        = 1'b0;
        step_req       = 1'b0;
        stop_req       = 1'b0;
        clear_req      = 1'b0;
        halt_flag_e    = 1'b0;
        branch_taken   = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_rt       = '0;
        if_id_rs       = '0;
        if_id_rt       = '0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        run_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pipe_enable, pc_write, if_id_write, bubble_id_ex, flush, halted, busy} !== 7'b0 ||
            cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_vals act ctl=%b cnt=%0d exp ctl=0000000 cnt=0",
                     {pipe_enable, pc_write, if_id_write, bubble_id_ex, flush, halted, busy},
                     cycle_count);
        end
        run_req = 1'b0;
        reset   = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_run_stop();
        run_req  = 1'b1;
        step_req = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL run_start act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
        clr();
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) stop_req = 1'b1;
            tick();
            exp_o = sb_q.pop_front();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL run_cyc%0d act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         i, act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
            end
            if (i == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL run_over_step act busy=%b exp busy=1", busy);
                end
            end
            adv();
            clr();
        end
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL run_stopped act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        checks++;
        if (cycle_count !== 32'd10 || busy !== 1'b0 || pipe_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_state act cnt=%0d busy=%b en=%b exp cnt=10 busy=0 en=0",
                     cycle_count, busy, pipe_enable);
        end
        adv();
    endtask

    task automatic test_step();
        int en_cycles = 0;
        int rises     = 0;
        logic prev    = 1'b0;
        for (int i = 0; i < 15; i++) begin
            // i==1 repeats the request while in STEP; it must be ignored
            step_req = (i % 5 == 0) || (i == 1);
            tick();
            exp_o = sb_q.pop_front();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL step_cyc%0d act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         i, act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
            end
            if (pipe_enable === 1'b1) en_cycles++;
            if (pipe_enable === 1'b1 && prev === 1'b0) rises++;
            prev = pipe_enable;
            adv();
            clr();
        end
        checks++;
        if (en_cycles != 3 || rises != 3) begin
            errors++;
            $display("FAIL step_pulses act cycles=%0d pulses=%0d exp cycles=3 pulses=3",
                     en_cycles, rises);
        end
        checks++;
        if (cycle_count !== 32'd13) begin
            errors++;
            $display("FAIL step_count act %0d exp 13", cycle_count);
        end
    endtask

    task automatic test_hazard();
        int   t_mr [6] = '{1, 1, 1, 0, 1, 1};
        int   t_xrt[6] = '{8, 0, 8, 8, 8, 9};
        int   t_rs [6] = '{8, 0, 3, 8, 8, 8};
        int   t_rt [6] = '{3, 0, 8, 3, 3, 10};
        int   t_br [6] = '{0, 0, 0, 0, 1, 0};
        logic [3:0] t_exp[6] = '{4'b0010, 4'b1100, 4'b0010, 4'b1100, 4'b1101, 4'b1100};
        run_req = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL hz_start act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
        clr();
        for (int k = 0; k < 6; k++) begin
            id_ex_mem_read = (t_mr[k] != 0);
            id_ex_rt       = NB'(t_xrt[k]);
            if_id_rs       = NB'(t_rs[k]);
            if_id_rt       = NB'(t_rt[k]);
            branch_taken   = (t_br[k] != 0);
            tick();
            exp_o = sb_q.pop_front();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL hz_model%0d act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         k, act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
            end
            checks++;
            if ({pc_write, if_id_write, bubble_id_ex, flush} !== t_exp[k]) begin
                errors++;
                $display("FAIL hz_ctl%0d act pc/ifid/bub/fl=%b exp %b",
                         k, {pc_write, if_id_write, bubble_id_ex, flush}, t_exp[k]);
            end
            adv();
            clr();
        end
        stop_req = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL hz_stop act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
        clr();
    endtask

    task automatic test_halt();
        logic en;
        run_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_o = sb_q.pop_front();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL halt_run%0d act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         i, act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
            end
            adv();
            clr();
        end
        // k=0 is cycle H: halt arrives together with stop; later requests ignored
        for (int k = 0; k < 6; k++) begin
            halt_flag_e  = (k == 0);
            stop_req     = (k == 0);
            run_req      = (k >= 1);
            step_req     = (k == 2);
            branch_taken = (k == 1);
            tick();
            exp_o = sb_q.pop_front();
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL halt_model%0d act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         k, act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
            end
            en = (k <= DC);
            checks++;
            if ({pipe_enable, pc_write, flush, halted} !== {en, 1'b0, en, ~en}) begin
                errors++;
                $display("FAIL halt_seq%0d act en/pc/fl/halted=%b exp %b",
                         k, {pipe_enable, pc_write, flush, halted}, {en, 1'b0, en, ~en});
            end
            adv();
            clr();
        end
        clear_req = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL halt_clear act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
        clr();
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL halt_idle act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        checks++;
        if (cycle_count !== '0 || halted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_state act cnt=%0d halted=%b busy=%b exp cnt=0 halted=0 busy=0",
                     cycle_count, halted, busy);
        end
        adv();
    endtask

    task automatic test_reset_drain();
        run_req = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        adv();
        clr();
        halt_flag_e = 1'b1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL rd_halt act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
        clr();
        // Now in the first DRAIN cycle; pull reset between edges
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({pipe_enable, pc_write, if_id_write, bubble_id_ex, flush, halted, busy} !== 7'b0 ||
            cycle_count !== '0) begin
            errors++;
            $display("FAIL reset_drain act ctl=%b cnt=%0d exp ctl=0000000 cnt=0",
                     {pipe_enable, pc_write, if_id_write, bubble_id_ex, flush, halted, busy},
                     cycle_count);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick();
        exp_o = sb_q.pop_front();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL rd_idle act ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                     act_o.ctl, act_o.cnt, exp_o.ctl, exp_o.cnt);
        end
        adv();
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_step();
        test_hazard();
        test_halt();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act timeout exp finish");
        $fatal(1);
    end

endmodule
